// File: rtl/alu_sout_tx.sv
// Serial result/error transmitter: shifts 11-bit packets onto sout, 55-bit result or 11-bit error frame.
// Latency: start bit on sout the cycle after an accepted start; done pulses the cycle after the last stop bit.
// Backpressure: none; start is accepted only while busy=0, and a start during busy is dropped. Optional CRC3 via `ALU_TX_CRC_EN.
module alu_sout_tx (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] c_in,
    input  logic [3:0]  flags_in,
    input  logic        err_in,
    input  logic [2:0]  err_flags_in,
    output logic        sout,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, DATA, CTL, ERR} state_t;

    state_t      state, state_nxt;
    logic [3:0]  bit_cnt, bit_cnt_nxt;
    logic [1:0]  byte_cnt, byte_cnt_nxt;
    logic        done_nxt;
    logic        capture;

    logic [31:0] c_q;
    logic [3:0]  flags_q;
    logic [2:0]  ef_q;

    logic [7:0]  data_byte;
    logic [10:0] pkt;
    logic [2:0]  crc;
    logic        err_par;

`ifdef ALU_TX_CRC_EN
    // Bit-serial CRC3 (x^3+x+1) unrolled over the 37-bit string; captured regs are stable all frame.
    function automatic logic [2:0] crc3(input logic [36:0] s);
        logic [2:0] r;
        logic       fb;
        r = 3'b000;
        for (int i = 36; i >= 0; i--) begin
            fb = r[2] ^ s[i];
            r  = {r[1], r[0] ^ fb, fb};
        end
        return r;
    endfunction

    assign crc = crc3({c_q, 1'b0, flags_q});
`else
    assign crc = 3'b000;
`endif

    // State, counters, done pulse and captured request fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= 4'd0;
            byte_cnt <= 2'd0;
            done     <= 1'b0;
            c_q      <= 32'd0;
            flags_q  <= 4'd0;
            ef_q     <= 3'd0;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_cnt_nxt;
            byte_cnt <= byte_cnt_nxt;
            done     <= done_nxt;
            if (capture) begin
                c_q     <= c_in;
                flags_q <= flags_in;
                ef_q    <= err_flags_in;
            end
        end
    end

    // Next-state: bit_cnt walks 10..0 per packet, byte_cnt selects the data byte.
    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        byte_cnt_nxt = byte_cnt;
        done_nxt     = 1'b0;
        capture      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    capture      = 1'b1;
                    bit_cnt_nxt  = 4'd10;
                    byte_cnt_nxt = 2'd0;
                    state_nxt    = err_in ? ERR : DATA;
                end
            end
            DATA: begin
                if (bit_cnt == 4'd0) begin
                    bit_cnt_nxt = 4'd10;
                    if (byte_cnt == 2'd3) begin
                        byte_cnt_nxt = 2'd0;
                        state_nxt    = CTL;
                    end else begin
                        byte_cnt_nxt = byte_cnt + 2'd1;
                    end
                end else begin
                    bit_cnt_nxt = bit_cnt - 4'd1;
                end
            end
            CTL, ERR: begin
                if (bit_cnt == 4'd0) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    bit_cnt_nxt = bit_cnt - 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Packet assembly for the current state; sout picks the bit under bit_cnt.
    always_comb begin
        data_byte = 8'd0;
        case (byte_cnt)
            2'd0: data_byte = c_q[31:24];
            2'd1: data_byte = c_q[23:16];
            2'd2: data_byte = c_q[15:8];
            2'd3: data_byte = c_q[7:0];
            default: data_byte = 8'd0;
        endcase
        err_par = ^{1'b1, ef_q, ef_q};
        pkt = 11'h7FF;
        case (state)
            DATA:    pkt = {2'b00, data_byte, 1'b1};
            CTL:     pkt = {3'b010, flags_q, crc, 1'b1};
            ERR:     pkt = {3'b011, ef_q, ef_q, err_par, 1'b1};
            default: pkt = 11'h7FF;
        endcase
        sout = (state == IDLE) ? 1'b1 : pkt[bit_cnt];
        busy = (state != IDLE);
    end

endmodule
